// File: rtl/intdiv_sequencer_pkg.sv
// Shared types and opcode constants for the iterative integer divider.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package intdiv_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divstate_t;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  function automatic logic is_signed_op(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

// File: rtl/intdiv_sequencer_if.sv
// Execute-stage <-> divider bundle; master is Execute, slave is the divider.
// Latency: none (wiring only).
// Backpressure: DivBusyE stalls Execute; StallE holds the finished result.
interface intdiv_sequencer_if #(parameter int XLEN = 64);

  logic            DivStartE;
  logic [2:0]      Funct3E;
  logic            W64E;
  logic [XLEN-1:0] ForwardedSrcAE;
  logic [XLEN-1:0] ForwardedSrcBE;
  logic            StallE;
  logic            FlushE;
  logic            DivBusyE;
  logic            DivDoneE;
  logic [XLEN-1:0] DivResultE;

  modport master (
    output DivStartE, Funct3E, W64E, ForwardedSrcAE, ForwardedSrcBE, StallE, FlushE,
    input  DivBusyE, DivDoneE, DivResultE
  );

  modport slave (
    input  DivStartE, Funct3E, W64E, ForwardedSrcAE, ForwardedSrcBE, StallE, FlushE,
    output DivBusyE, DivDoneE, DivResultE
  );

endinterface

// File: rtl/intdiv_step.sv
// One restoring division step: shift in a dividend bit, subtract if it fits.
// Latency: combinational.
// Backpressure: none.
module intdiv_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            dvd_bit,
  output logic [XLEN:0]   rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Trial subtraction; keep the difference only when the divisor fits
  always_comb begin
    shifted = {rem_in[XLEN-1:0], dvd_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = rem_in[XLEN] | (shifted >= {1'b0, divisor});
    rem_out = q_bit ? diff : shifted;
  end

endmodule

// File: rtl/intdiv_sequencer.sv
// Radix-2 restoring DIV/DIVU/REM/REMU (+W forms) sequencer; macro INTDIV_SPECIAL_CASE_EN enables early-out.
// Latency: done N+1 cycles after start (N=32 word/XLEN32, 64 otherwise); 1 cycle for early-out cases.
// Backpressure: DivBusyE stalls Execute; result held in DONE while StallE, FlushE aborts.
module intdiv_sequencer
  import intdiv_sequencer_pkg::*;
#(
  parameter int XLEN = 64
) (
  input logic               clk,
  input logic               reset,
  intdiv_sequencer_if.slave bus
);

  localparam int CW    = $clog2(XLEN + 1);
  localparam bit HAS_W = (XLEN == 64);

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v, input logic w);
    sext_w = v;
    if (w) for (int i = 32; i < XLEN; i++) sext_w[i] = v[31];
  endfunction

  divstate_t       state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] dvd_q, dvs_q, a_q, result_q;
  logic [XLEN:0]   rem_q, rem_nxt;
  logic            neg_a_q, neg_b_q, rem_op_q, w_q, div0_q;
  logic            busy, done, accept, step, qbit;

  logic            sgn, w_in, rem_in_op, neg_a, neg_b, div0_in, special_in;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs;
  logic [XLEN-1:0] q_fin, r_fin, q_fix, r_fix, fin_res;

  // Operand decode: word-form extension, sign detection and magnitudes
  always_comb begin
    sgn       = is_signed_op(bus.Funct3E);
    rem_in_op = is_rem_op(bus.Funct3E);
    w_in      = HAS_W && bus.W64E;
    a_ext     = bus.ForwardedSrcAE;
    b_ext     = bus.ForwardedSrcBE;
    if (w_in) begin
      for (int i = 32; i < XLEN; i++) begin
        a_ext[i] = sgn & bus.ForwardedSrcAE[31];
        b_ext[i] = sgn & bus.ForwardedSrcBE[31];
      end
    end
    neg_a   = sgn & a_ext[XLEN-1];
    neg_b   = sgn & b_ext[XLEN-1];
    a_abs   = neg_a ? -a_ext : a_ext;
    b_abs   = neg_b ? -b_ext : b_ext;
    div0_in = (b_ext == '0);
  end

`ifdef INTDIV_SPECIAL_CASE_EN
  logic            ovf_in;
  logic [XLEN-1:0] min_v, spec_res;

  // Early result for divide-by-zero and MIN/-1 so they skip the iterations
  always_comb begin
    min_v = '0;
    if (w_in) min_v[31] = 1'b1;
    else      min_v[XLEN-1] = 1'b1;
    min_v  = sext_w(min_v, w_in);
    ovf_in = sgn && (a_ext == min_v) && (b_ext == '1);
    if (div0_in) spec_res = rem_in_op ? a_ext : '1;
    else         spec_res = rem_in_op ? '0 : a_ext;
    spec_res = sext_w(spec_res, w_in);
  end
  assign special_in = div0_in | ovf_in;
`else
  assign special_in = 1'b0;
`endif

  intdiv_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .divisor (dvs_q),
    .dvd_bit (dvd_q[XLEN-1]),
    .rem_out (rem_nxt),
    .q_bit   (qbit)
  );

  // Sign fix-up of the final step; divide-by-zero forced since |A|/0 has the wrong sign
  always_comb begin
    q_fin = {dvd_q[XLEN-2:0], qbit};
    r_fin = rem_nxt[XLEN-1:0];
    q_fix = (neg_a_q ^ neg_b_q) ? -q_fin : q_fin;
    r_fix = neg_a_q ? -r_fin : r_fin;
    if (div0_q) begin
      q_fix = '1;
      r_fix = a_q;
    end
    fin_res = sext_w(rem_op_q ? r_fix : q_fix, w_q);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.DivStartE && !bus.FlushE) begin
          accept  = 1'b1;
          busy    = 1'b1;
          state_d = special_in ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (bus.FlushE) begin
          state_d = IDLE;
        end else begin
          busy = 1'b1;
          step = 1'b1;
          if (cnt_q == CW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (bus.FlushE || !bus.StallE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, iteration registers and result register
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      a_q      <= '0;
      rem_q    <= '0;
      result_q <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      rem_op_q <= 1'b0;
      w_q      <= 1'b0;
      div0_q   <= 1'b0;
    end else if (accept) begin
      // Word ops start with the 32-bit magnitude in the top half so the MSB-first walk sees it first
      dvd_q    <= w_in ? (a_abs << 32) : a_abs;
      dvs_q    <= b_abs;
      a_q      <= a_ext;
      rem_q    <= '0;
      neg_a_q  <= neg_a;
      neg_b_q  <= neg_b;
      rem_op_q <= rem_in_op;
      w_q      <= w_in;
      div0_q   <= div0_in;
      cnt_q    <= w_in ? CW'(32) : CW'(XLEN);
`ifdef INTDIV_SPECIAL_CASE_EN
      if (special_in) result_q <= spec_res;
`endif
    end else if (step) begin
      rem_q <= rem_nxt;
      dvd_q <= {dvd_q[XLEN-2:0], qbit};
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) result_q <= fin_res;
    end else if (state_q == BUSY) begin
      cnt_q <= '0;
    end
  end

  assign bus.DivBusyE   = busy;
  assign bus.DivDoneE   = done;
  assign bus.DivResultE = result_q;

endmodule
